// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - obstacle slot sequencer and game-state FSM for the runner game
//
// Purpose: owns three obstacle slots (valid, x, type). It spawns slots at randomised
// frame intervals, scrolls them left at a speed that ramps with play time, and retires
// them once they leave the screen. It also runs the IDLE / RUN / HALT game-state FSM.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   frame_tick one-cycle pulse per video frame
//   start      debounced button level; a 0->1 edge is a press
//   collide    collision flag from the renderer
//   random     LFSR value, used only when a slot spawns
//   obj_valid  per-slot valid
//   obj_x      slot i x-position at [11i+10:11i]
//   obj_type   slot i type at [2i+1:2i] (0..2)
//   speed      pixels per frame
//   score      frames survived in the current run (saturating)
//   state      0=IDLE, 1=RUN, 2=HALT
module obstacle_scheduler #(
  parameter int SPAWN_X    = 640,
  parameter int MIN_GAP    = 40,
  parameter int INIT_SPEED = 2,
  parameter int MAX_SPEED  = 8,
  parameter int SPEED_STEP = 600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        collide,
  input  logic [4:0]  random,
  output logic [2:0]  obj_valid,
  output logic [32:0] obj_x,
  output logic [5:0]  obj_type,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int              STEP_W       = $clog2(SPEED_STEP + 1);
  localparam logic [10:0]     SPAWN_X_W    = 11'(SPAWN_X);
  localparam logic [7:0]      MIN_GAP_W    = 8'(MIN_GAP);
  localparam logic [3:0]      INIT_SPEED_W = 4'(INIT_SPEED);
  localparam logic [3:0]      MAX_SPEED_W  = 4'(MAX_SPEED);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(SPEED_STEP - 1);

  // Registered state
  state_t              r_state;
  logic [2:0]          r_valid;
  logic [32:0]         r_x;
  logic [5:0]          r_type;
  logic [3:0]          r_speed;
  logic [15:0]         r_score;
  logic [7:0]          r_timer;
  logic [STEP_W-1:0]   r_step;
  logic                r_start_d;

  // Next-state values
  state_t              w_state_nxt;
  logic [2:0]          w_valid_nxt;
  logic [32:0]         w_x_nxt;
  logic [5:0]          w_type_nxt;
  logic [3:0]          w_speed_nxt;
  logic [15:0]         w_score_nxt;
  logic [7:0]          w_timer_nxt;
  logic [STEP_W-1:0]   w_step_nxt;

  logic                w_press;
  logic [7:0]          w_timer_dec;
  logic                w_found;
  int                  w_slot;
  logic [1:0]          w_rand_type;
  logic [10:0]         w_cur_x;

  // Type code 3 is not a valid obstacle, so it folds onto cactus1.
  assign w_rand_type = (random[1:0] == 2'd3) ? 2'd0 : random[1:0];

  always_comb begin
    w_press     = start & ~r_start_d;
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_x_nxt     = r_x;
    w_type_nxt  = r_type;
    w_speed_nxt = r_speed;
    w_score_nxt = r_score;
    w_timer_nxt = r_timer;
    w_step_nxt  = r_step;
    w_timer_dec = r_timer;
    w_found     = 1'b0;
    w_slot      = 0;
    w_cur_x     = '0;

    case (r_state)
      ST_IDLE, ST_HALT: begin
        // A press starts a fresh run from either state; collide is not looked at
        // here, so a restart while still colliding halts again on the next cycle.
        if (w_press) begin
          w_state_nxt = ST_RUN;
          w_valid_nxt = '0;
          w_x_nxt     = '0;
          w_type_nxt  = '0;
          w_score_nxt = '0;
          w_speed_nxt = INIT_SPEED_W;
          w_timer_nxt = MIN_GAP_W;
          w_step_nxt  = '0;
        end
      end

      ST_RUN: begin
        if (collide) begin
          // Collision wins over a coincident frame tick: the frame is frozen as is.
          w_state_nxt = ST_HALT;
        end else if (frame_tick) begin
          // Move or retire every live slot using the speed in effect this frame.
          for (int i = 0; i < 3; i++) begin
            w_cur_x = r_x[i*11 +: 11];
            if (r_valid[i]) begin
              if (w_cur_x >= {7'd0, r_speed}) begin
                w_x_nxt[i*11 +: 11] = w_cur_x - {7'd0, r_speed};
              end else begin
                w_valid_nxt[i] = 1'b0;
              end
            end
          end

          if (r_score != 16'hFFFF) begin
            w_score_nxt = r_score + 16'd1;
          end

          if (r_step == STEP_LAST) begin
            w_step_nxt = '0;
            if (r_speed < MAX_SPEED_W) begin
              w_speed_nxt = r_speed + 4'd1;
            end
          end else begin
            w_step_nxt = r_step + STEP_W'(1);
          end

          w_timer_dec = (r_timer != 8'd0) ? (r_timer - 8'd1) : 8'd0;
          w_timer_nxt = w_timer_dec;

          // Spawn into the lowest free slot, seeing slots freed by this frame's
          // retirement. With no free slot the timer parks at 0 and retries.
          if (w_timer_dec == 8'd0) begin
            for (int i = 0; i < 3; i++) begin
              if (!w_valid_nxt[i] && !w_found) begin
                w_found = 1'b1;
                w_slot  = i;
              end
            end
            if (w_found) begin
              w_valid_nxt[w_slot]        = 1'b1;
              w_x_nxt[w_slot*11 +: 11]   = SPAWN_X_W;
              w_type_nxt[w_slot*2 +: 2]  = w_rand_type;
              w_timer_nxt = MIN_GAP_W + {2'b00, random[4:2], 3'b000};
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= '0;
      r_x       <= '0;
      r_type    <= '0;
      r_speed   <= INIT_SPEED_W;
      r_score   <= '0;
      r_timer   <= MIN_GAP_W;
      r_step    <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_x       <= w_x_nxt;
      r_type    <= w_type_nxt;
      r_speed   <= w_speed_nxt;
      r_score   <= w_score_nxt;
      r_timer   <= w_timer_nxt;
      r_step    <= w_step_nxt;
      r_start_d <= start;
    end
  end

  assign obj_valid = r_valid;
  assign obj_x     = r_x;
  assign obj_type  = r_type;
  assign speed     = r_speed;
  assign score     = r_score;
  assign state     = r_state;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - scoreboard bench for obstacle_scheduler
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic        start;
  logic        collide;
  logic [4:0]  random;
  logic [2:0]  obj_valid;
  logic [32:0] obj_x;
  logic [5:0]  obj_type;
  logic [3:0]  speed;
  logic [15:0] score;
  logic [1:0]  state;

  always #5 clk = ~clk;

  obstacle_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .start      (start),
    .collide    (collide),
    .random     (random),
    .obj_valid  (obj_valid),
    .obj_x      (obj_x),
    .obj_type   (obj_type),
    .speed      (speed),
    .score      (score),
    .state      (state)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [2:0]  v;
    logic [32:0] x;
    logic [5:0]  ty;
    logic [3:0]  sp;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: game rules expressed directly on slot arrays.
  int m_state;
  bit m_valid[3];
  int m_x[3];
  int m_type[3];
  int m_speed, m_score, m_timer, m_step;
  bit m_prev;

  function void model_clear();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0;
      m_x[i]     = 0;
      m_type[i]  = 0;
    end
    m_speed = 2;
    m_score = 0;
    m_timer = 40;
    m_step  = 0;
  endfunction

  function void model_reset();
    model_clear();
    m_state = 0;
    m_prev  = 0;
  endfunction

  function void model_tick(input int rnd);
    bit found;
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        if (m_x[i] >= m_speed) m_x[i] = m_x[i] - m_speed;
        else m_valid[i] = 0;
      end
    end
    if (m_score < 65535) m_score++;
    m_step++;
    if (m_step == 600) begin
      m_step = 0;
      if (m_speed < 8) m_speed++;
    end
    if (m_timer != 0) m_timer--;
    if (m_timer == 0) begin
      found = 0;
      for (int i = 0; i < 3; i++) begin
        if (!found && !m_valid[i]) begin
          found      = 1;
          m_valid[i] = 1;
          m_x[i]     = 640;
          m_type[i]  = ((rnd % 4) == 3) ? 0 : (rnd % 4);
          m_timer    = 40 + ((rnd / 4) % 8) * 8;
        end
      end
    end
  endfunction

  function void model_step(input bit rstn, input bit fr, input bit st, input bit col, input int rnd);
    bit press;
    if (!rstn) begin
      model_reset();
      return;
    end
    press  = st && !m_prev;
    m_prev = st;
    case (m_state)
      1: begin
        if (col) m_state = 2;
        else if (fr) model_tick(rnd);
      end
      default: begin
        if (press) begin
          model_clear();
          m_state = 1;
        end
      end
    endcase
  endfunction

  function exp_t snapshot();
    exp_t e;
    e.st = m_state[1:0];
    e.sp = m_speed[3:0];
    e.sc = m_score[15:0];
    e.x  = '0;
    e.v  = '0;
    e.ty = '0;
    for (int i = 0; i < 3; i++) begin
      e.v[i]         = m_valid[i];
      e.x[i*11 +: 11] = m_x[i][10:0];
      e.ty[i*2 +: 2]  = m_type[i][1:0];
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so every pushed expectation is due right after its edge.
  always @(posedge clk) begin
    #1;
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("state",     64'(state),     64'(e.st));
      check("obj_valid", 64'(obj_valid), 64'(e.v));
      check("obj_x",     64'(obj_x),     64'(e.x));
      check("obj_type",  64'(obj_type),  64'(e.ty));
      check("speed",     64'(speed),     64'(e.sp));
      check("score",     64'(score),     64'(e.sc));
    end
  end

  task automatic cyc(input logic rstn, input logic fr, input logic st, input logic col,
                     input logic [4:0] rnd, input bit chk);
    @(negedge clk);
    reset_n    = rstn;
    frame_tick = fr;
    start      = st;
    collide    = col;
    random     = rnd;
    @(posedge clk);
    model_step(rstn, fr, st, col, int'(rnd));
    if (chk) q.push_back(snapshot());
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] r;
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    collide    = 1'b0;
    random     = 5'd0;
    model_reset();

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);

    // Idle: frame ticks without a press do nothing.
    repeat (100) cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom), 1'b1);

    // First spawn with random=10101, then keep start held (no new press).
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'b10101, 1'b1);
    repeat (45) cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'b10101, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'b10101, 1'b1);

    // Randomised play: ticks, occasional collisions and presses.
    for (int n = 0; n < 2500; n++) begin
      r = 5'($urandom);
      cyc(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 149) == 0), r, 1'b1);
    end

    // Collision priority, frozen HALT, restart while still colliding.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    repeat (45) cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom), 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'($urandom), 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom), 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'($urandom), 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    repeat (50) cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom), 1'b1);

    // Reset in the middle of a ticking frame.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'($urandom), 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);

    // Long run: speed ramps to saturation, score saturates at 0xFFFF.
    for (int n = 0; n < 65540; n++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom),
          (n < 5000) || (n % 1000 == 0) || (n > 65530));
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);

    @(posedge clk);
    #2;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Sequences the obstacle layer of the runner game. Owns three obstacle slots, each with valid, x-position and type. Spawns slots at randomised frame intervals, scrolls them left at a speed that ramps with play time, and retires them off-screen. Runs the game-state FSM (idle / run / halted on collision / restart), replacing the ad-hoc select/type logic beside the pixel renderer.

Parameters:
SPAWN_X, 640, x-position a new obstacle takes on spawn (right edge of visible area)
MIN_GAP, 40, minimum frames between spawns
INIT_SPEED, 2, pixels per frame after start/restart
MAX_SPEED, 8, speed saturation value
SPEED_STEP, 600, frames of RUN between speed increments

Ports:
clk  input  1  pixel/system clock
reset_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse per video frame (start of vertical blank)
start  input  1  synchronised, debounced button level
collide  input  1  collision flag from renderer
random  input  5  LFSR output, sampled only on spawn
obj_valid  output  3  per-slot valid
obj_x  output  33  slot i x-position at bits [11i+10:11i], unsigned
obj_type  output  6  slot i type at bits [2i+1:2i]; 0=cactus1, 1=cactus2, 2=cactus3
speed  output  4  current pixels/frame
score  output  16  frames survived in the current run
state  output  2  0=IDLE, 1=RUN, 2=HALT

Behaviour:
- reset_n low (async): state=IDLE; obj_valid=0, obj_x=0, obj_type=0; speed=INIT_SPEED; score=0; spawn timer=MIN_GAP; step counter=0.
- All outputs are registered. Every change takes effect on the clk edge that samples the event.
- start edge detection: internal register; a "press" is a start rising edge (0->1).
- IDLE: on press -> RUN. Slots cleared, score=0, speed=INIT_SPEED, timer=MIN_GAP, step counter=0.
- RUN: collide=1 -> HALT on that edge. Collide has priority over a coincident frame_tick, so nothing moves and score does not increment. Press is ignored. Otherwise, on frame_tick, apply in this order:
  1. Move: every valid slot with x >= speed gets x -= speed. Every valid slot with x < speed is retired (valid=0, x unchanged).
  2. Score: score += 1, saturating at 0xFFFF.
  3. Speed: step counter += 1. When it reaches SPEED_STEP it resets to 0 and speed += 1, saturating at MAX_SPEED.
  4. Spawn: if timer != 0, timer -= 1. If timer == 0 and a slot is free after step 1, take the lowest-index free slot:
     - valid=1, x=SPAWN_X (not moved this frame);
     - type = random[1:0], with 3 mapped to 0;
     - timer = MIN_GAP + {random[4:2],3'b000} (range MIN_GAP..MIN_GAP+56). Internal arithmetic is 8-bit, so MIN_GAP <= 199.
     If timer == 0 and no slot is free, timer holds 0 and the spawn retries on every later frame_tick.
- A slot retired in step 1 may be respawned in step 4 of the same tick.
- HALT: everything frozen, and frame_tick is ignored. On press -> RUN with the same clear as the IDLE->RUN transition. If collide is still 1 at the press, the restart still happens. Collide is re-evaluated only from the next cycle.
- frame_tick outside RUN has no effect.
- reset_n asserted mid-frame or mid-spawn: immediate return to reset values; no partial slot update survives.

Test Plan:
- Reset then idle: hold reset_n low, release, issue 100 frame_ticks with no press -> state=0, obj_valid=000, score=0, speed=2.
- First spawn: press, random=5'b10101, 40 frame_ticks -> on the 40th tick slot0 valid, x=640, type=1, timer=40+40=80; on the 41st tick x=638.
- Retire boundary: slot x=3 with speed=2 -> ticks give x=1, then retired (valid=0). With x=2, speed=2 -> x=0, then retired on the next tick.
- Slots full: force all three valid with timer at 0 -> timer holds 0 and no spawn. When slot1 retires, spawn lands in slot1 on that same tick.
- Collision priority: collide and frame_tick asserted in the same cycle while in RUN -> state=2, and x/score unchanged. A later press gives state=1, score=0, obj_valid=000, speed=2.
- Speed ramp: SPEED_STEP=600, 600*7 frame_ticks -> speed=8, and it stays 8 after 600 more ticks. score equals the tick count, and with 0xFFFF+5 ticks it saturates at 0xFFFF.
